// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative MULT/MULTU/DIV/DIVU into HI/LO.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for multiply/divide.
// Backpressure: busy=1 while iterating; start is ignored (not queued) until busy drops.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zeroFlag,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divZero
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_MULT  = 4'b0100;
   localparam logic [3:0] OP_MULTU = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_DIV   = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CALC = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   // counter must hold the value WIDTH itself
   localparam int CW = $clog2(WIDTH) + 1;

   logic [1:0]         state_q, state_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;   // negate product / quotient at the end
   logic               neg_rem_q, neg_rem_d;   // negate remainder (dividend was negative)
   logic [WIDTH-1:0]   mag_q, mag_d;           // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] p_q, p_d;               // {upper, lower} shift register
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dz_q, dz_d;
   logic               done_q, done_d;

   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   alu_res;
   logic               is_iter, is_div_op, signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   op1_mag, op2_mag;
   logic [WIDTH:0]     mul_sum, div_rem, div_sub;
   logic               div_ok;
   logic [2*WIDTH-1:0] step_p, prod;
   logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

   // single-cycle datapath straight from the operand inputs
   always_comb begin
      shamt   = operand2[SHW-1:0];
      alu_res = '0;
      case (operation)
         OP_AND: alu_res = operand1 & operand2;
         OP_OR:  alu_res = operand1 | operand2;
         OP_ADD: alu_res = operand1 + operand2;
         OP_SUB: alu_res = operand1 - operand2;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
         OP_NOR: alu_res = ~(operand1 | operand2);
         OP_XOR: alu_res = operand1 ^ operand2;
         OP_SLL: alu_res = operand1 << shamt;
         OP_SRL: alu_res = operand1 >> shamt;
         OP_SRA: alu_res = $signed(operand1) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   // operand classification and magnitudes for the iterative engine
   always_comb begin
      is_div_op = (operation == OP_DIV) || (operation == OP_DIVU);
      is_iter   = is_div_op || (operation == OP_MULT) || (operation == OP_MULTU);
      signed_op = (operation == OP_MULT) || (operation == OP_DIV);
      a_neg     = signed_op && operand1[WIDTH-1];
      b_neg     = signed_op && operand2[WIDTH-1];
      op1_mag   = a_neg ? (~operand1 + 1'b1) : operand1;
      op2_mag   = b_neg ? (~operand2 + 1'b1) : operand2;
   end

   // one shift-add or restoring-subtract step, plus sign correction of the final step
   always_comb begin
      mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mag_q} : '0);
      // remainder shifted left with the next dividend bit; needs WIDTH+1 bits
      div_rem = p_q[2*WIDTH-1:WIDTH-1];
      div_sub = div_rem - {1'b0, mag_q};
      div_ok  = (div_rem >= {1'b0, mag_q});
      if (is_div_q) begin
         step_p = {(div_ok ? div_sub[WIDTH-1:0] : div_rem[WIDTH-1:0]), p_q[WIDTH-2:0], div_ok};
      end else begin
         step_p = {mul_sum, p_q[WIDTH-1:1]};
      end
      prod = neg_res_q ? (~step_p + 1'b1) : step_p;
      quo  = step_p[WIDTH-1:0];
      rem  = step_p[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         fin_lo = neg_res_q ? (~quo + 1'b1) : quo;
         fin_hi = neg_rem_q ? (~rem + 1'b1) : rem;
      end else begin
         fin_lo = prod[WIDTH-1:0];
         fin_hi = prod[2*WIDTH-1:WIDTH];
      end
   end

   // control FSM and next-value selection for all architectural registers
   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      mag_d     = mag_q;
      p_d       = p_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            // the done cycle accepts a new start exactly like idle
            state_d = S_IDLE;
            if (start) begin
               if (is_div_op && (operand2 == '0)) begin
                  result_d = '1;
                  zero_d   = 1'b0;
                  lo_d     = '1;
                  hi_d     = operand1;
                  dz_d     = 1'b1;
                  done_d   = 1'b1;
               end else if (is_iter) begin
                  is_div_d  = is_div_op;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  mag_d     = is_div_op ? op2_mag : op1_mag;
                  p_d       = {{WIDTH{1'b0}}, (is_div_op ? op1_mag : op2_mag)};
                  cnt_d     = CW'(WIDTH);
                  state_d   = S_CALC;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  dz_d     = 1'b0;
                  done_d   = 1'b1;
               end
            end
         end
         S_CALC: begin
            p_d   = step_p;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               hi_d     = fin_hi;
               lo_d     = fin_lo;
               result_d = fin_lo;
               zero_d   = (fin_lo == '0);
               dz_d     = 1'b0;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state registers with synchronous reset; reset aborts any iteration
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         mag_q     <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         mag_q     <= mag_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
      end
   end

   assign busy     = (state_q == S_CALC);
   assign done     = done_q;
   assign result   = result_q;
   assign zeroFlag = zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign divZero  = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, multi-cycle corner sequences, randomized ops vs reference model.
// Latency: checks 1-cycle and WIDTH+1-cycle completion and busy cycle counts.
// Backpressure: exercises start-while-busy, start-in-done-cycle and mid-operation reset.
module tb_seq_alu;
   localparam int W = 32;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_MULT  = 4'b0100;
   localparam logic [3:0] OP_MULTU = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_UND   = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_DIV   = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   operation;
   logic [W-1:0] operand1, operand2;
   logic         busy, done, zeroFlag, divZero;
   logic [W-1:0] result, hi, lo;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_res, m_hi, m_lo;
   logic        m_dz;
   int          m_lat;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t tbl [21];

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .operation(operation),
      .operand1(operand1), .operand2(operand2), .busy(busy), .done(done),
      .result(result), .zeroFlag(zeroFlag), .hi(hi), .lo(lo), .divZero(divZero)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
      if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) return 1;
      if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) return W + 1;
      return 1;
   endfunction

   // behavioural reference using wide integer arithmetic
   task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m_dz  = 1'b0;
      m_lat = exp_lat(op, b);
      case (op)
         OP_AND: m_res = a & b;
         OP_OR:  m_res = a | b;
         OP_ADD: m_res = 32'(sa + sb);
         OP_SUB: m_res = 32'(sa - sb);
         OP_SLT: m_res = (sa < sb) ? 32'd1 : 32'd0;
         OP_NOR: m_res = ~(a | b);
         OP_XOR: m_res = a ^ b;
         OP_SLL: m_res = a << b[4:0];
         OP_SRL: m_res = a >> b[4:0];
         OP_SRA: m_res = $signed(a) >>> b[4:0];
         OP_MULT: begin
            p = 64'(sa * sb);
            m_hi = p[63:32]; m_lo = p[31:0]; m_res = m_lo;
         end
         OP_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; m_res = m_lo;
         end
         OP_DIV, OP_DIVU: begin
            if (b == 32'd0) begin
               m_dz = 1'b1; m_lo = 32'hFFFF_FFFF; m_hi = a; m_res = m_lo;
            end else begin
               if (op == OP_DIV) begin
                  q = sa / sb; r = sa % sb;
               end else begin
                  q = longint'({32'd0, a}) / longint'({32'd0, b});
                  r = longint'({32'd0, a}) % longint'({32'd0, b});
               end
               m_lo = 32'(q); m_hi = 32'(r); m_res = m_lo;
            end
         end
         default: m_res = 32'd0;
      endcase
   endtask

   // issue one op from idle, wait for done, check everything, then check the pulse ends
   task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int elat);
      int lat, bcnt, guard;
      guard = 0;
      while (busy && guard < 100) begin tick(); guard++; end
      operation = op; operand1 = a; operand2 = b; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < W + 8) begin
         if (busy) bcnt++;
         tick();
         lat++;
      end
      chk({nm, " done"},   64'(done),     64'(1));
      chk({nm, " lat"},    64'(lat),      64'(elat));
      chk({nm, " busycy"}, 64'(bcnt),     64'(elat - 1));
      chk({nm, " busy"},   64'(busy),     64'(0));
      chk({nm, " result"}, 64'(result),   64'(er));
      chk({nm, " zero"},   64'(zeroFlag), 64'(er == 32'd0));
      chk({nm, " hi"},     64'(hi),       64'(eh));
      chk({nm, " lo"},     64'(lo),       64'(el));
      chk({nm, " divz"},   64'(divZero),  64'(edz));
      tick();
      chk({nm, " pulse"},  64'(done),     64'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, npulse;
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      tbl[0]  = '{OP_ADD,   32'd5,         32'd6,         32'd11,        32'd0,         32'd0,         1'b0};
      tbl[1]  = '{OP_SUB,   32'd15,        32'd15,        32'd0,         32'd0,         32'd0,         1'b0};
      tbl[2]  = '{OP_NOR,   32'hAAAAAAAA,  32'h55555555,  32'd0,         32'd0,         32'd0,         1'b0};
      tbl[3]  = '{OP_SLT,   32'd15,        32'd16,        32'd1,         32'd0,         32'd0,         1'b0};
      tbl[4]  = '{OP_SLT,   32'hFFFFFFFF,  32'd1,         32'd1,         32'd0,         32'd0,         1'b0};
      tbl[5]  = '{OP_SRA,   32'h80000000,  32'd4,         32'hF8000000,  32'd0,         32'd0,         1'b0};
      tbl[6]  = '{OP_MULT,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFA,  32'hFFFFFFFF,  32'hFFFFFFFA,  1'b0};
      tbl[7]  = '{OP_MULTU, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFE,  1'b0};
      tbl[8]  = '{OP_DIV,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  32'hFFFFFFFD,  1'b0};
      tbl[9]  = '{OP_DIVU,  32'd7,         32'd0,         32'hFFFFFFFF,  32'd7,         32'hFFFFFFFF,  1'b1};
      tbl[10] = '{OP_XOR,   32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0,  32'd7,         32'hFFFFFFFF,  1'b0};
      tbl[11] = '{OP_SLL,   32'd1,         32'h21,        32'd2,         32'd7,         32'hFFFFFFFF,  1'b0};
      tbl[12] = '{OP_SRL,   32'h80000000,  32'h1F,        32'd1,         32'd7,         32'hFFFFFFFF,  1'b0};
      tbl[13] = '{OP_UND,   32'h12345678,  32'd1,         32'd0,         32'd7,         32'hFFFFFFFF,  1'b0};
      tbl[14] = '{OP_DIV,   32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         32'h80000000,  1'b0};
      tbl[15] = '{OP_DIVU,  32'd100,       32'd7,         32'd14,        32'd2,         32'd14,        1'b0};
      tbl[16] = '{OP_AND,   32'hFFFF0000,  32'h0F0F0F0F,  32'h0F0F0000,  32'd2,         32'd14,        1'b0};
      tbl[17] = '{OP_OR,    32'd0,         32'd0,         32'd0,         32'd2,         32'd14,        1'b0};
      tbl[18] = '{OP_DIV,   32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         32'hFFFFFFFD,  1'b0};
      tbl[19] = '{OP_MULT,  32'h80000000,  32'h80000000,  32'd0,         32'h40000000,  32'd0,         1'b0};
      tbl[20] = '{OP_SUB,   32'd0,         32'd1,         32'hFFFFFFFF,  32'h40000000,  32'd0,         1'b0};

      rst = 1'b1; start = 1'b0; operation = 4'd0; operand1 = '0; operand2 = '0;
      m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0; m_dz = 1'b0; m_lat = 1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst busy",   64'(busy),     64'(0));
      chk("rst done",   64'(done),     64'(0));
      chk("rst result", 64'(result),   64'(0));
      chk("rst zero",   64'(zeroFlag), 64'(1));
      chk("rst hi",     64'(hi),       64'(0));
      chk("rst lo",     64'(lo),       64'(0));
      chk("rst divz",   64'(divZero),  64'(0));

      for (int i = 0; i < 21; i++) begin
         ref_op(tbl[i].op, tbl[i].a, tbl[i].b);
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].res, tbl[i].hi, tbl[i].lo, tbl[i].dz, exp_lat(tbl[i].op, tbl[i].b));
      end

      // start while busy is ignored and not queued
      ref_op(OP_MULT, 32'd7, 32'd6);
      operation = OP_MULT; operand1 = 32'd7; operand2 = 32'd6; start = 1'b1;
      tick(); start = 1'b0; lat = 1;
      repeat (3) begin tick(); lat++; end
      operation = OP_ADD; operand1 = 32'd1; operand2 = 32'd1; start = 1'b1;
      tick(); start = 1'b0; lat++;
      chk("ign busy", 64'(busy), 64'(1));
      while (!done && lat < W + 8) begin tick(); lat++; end
      chk("ign lat",    64'(lat),    64'(W + 1));
      chk("ign result", 64'(result), 64'(42));
      chk("ign hi",     64'(hi),     64'(0));
      chk("ign lo",     64'(lo),     64'(42));
      tick();
      chk("ign noqueue done", 64'(done), 64'(0));
      chk("ign noqueue busy", 64'(busy), 64'(0));

      // start in the done cycle is accepted
      ref_op(OP_MULT, 32'd3, 32'd5);
      operation = OP_MULT; operand1 = 32'd3; operand2 = 32'd5; start = 1'b1;
      tick(); start = 1'b0; lat = 1;
      while (!done && lat < W + 8) begin tick(); lat++; end
      chk("b2b mult lat", 64'(lat), 64'(W + 1));
      chk("b2b mult lo",  64'(lo),  64'(15));
      ref_op(OP_ADD, 32'd1, 32'd1);
      operation = OP_ADD; operand1 = 32'd1; operand2 = 32'd1; start = 1'b1;
      tick(); start = 1'b0;
      chk("b2b add done",   64'(done),     64'(1));
      chk("b2b add result", 64'(result),   64'(2));
      chk("b2b add zero",   64'(zeroFlag), 64'(0));
      chk("b2b add hi",     64'(hi),       64'(0));
      chk("b2b add lo",     64'(lo),       64'(15));
      tick();
      chk("b2b add pulse",  64'(done),     64'(0));

      // reset in the middle of a divide
      operation = OP_DIVU; operand1 = 32'd1000; operand2 = 32'd3; start = 1'b1;
      tick(); start = 1'b0; lat = 1; npulse = 0;
      while (lat < 10) begin
         if (done) npulse++;
         tick(); lat++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      chk("mrst busy",   64'(busy),     64'(0));
      chk("mrst done",   64'(done),     64'(0));
      chk("mrst hi",     64'(hi),       64'(0));
      chk("mrst lo",     64'(lo),       64'(0));
      chk("mrst result", 64'(result),   64'(0));
      chk("mrst zero",   64'(zeroFlag), 64'(1));
      for (int k = 0; k < W + 8; k++) begin
         if (done) npulse++;
         tick();
      end
      chk("mrst nodone", 64'(npulse), 64'(0));
      ref_op(OP_DIVU, 32'd1000, 32'd3);
      do_op("mrst fresh", OP_DIVU, 32'd1000, 32'd3, 32'd333, 32'd1, 32'd333, 1'b0, W + 1);

      // randomized ops against the reference model
      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 5));
            2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            3: ra = 32'($urandom_range(0, 3));
            default: ;
         endcase
         ref_op(rop, ra, rb);
         do_op($sformatf("rnd%0d op%h", i, rop), rop, ra, rb, m_res, m_hi, m_lo, m_dz, m_lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
